// File: rtl/nv_fifo_ctrl_rwsthp_if.sv
// Producer/consumer handshake bundle for nv_fifo_ctrl_rwsthp.
// A transfer happens on a rising clock edge where valid & ready are both 1; valid never
// waits on ready, and the payload stays stable while valid=1 and ready=0.
interface nv_fifo_ctrl_rwsthp_if #(
  parameter int WIDTH = 4
);
  logic             wr_pvld;
  logic             wr_prdy;
  logic [WIDTH-1:0] wr_pd;
  logic             rd_pvld;
  logic             rd_prdy;
  logic [WIDTH-1:0] rd_pd;

  modport master (
    output wr_pvld, wr_pd, rd_prdy,
    input  wr_prdy, rd_pvld, rd_pd
  );

  modport slave (
    input  wr_pvld, wr_pd, rd_prdy,
    output wr_prdy, rd_pvld, rd_pd
  );
endinterface

// File: rtl/nv_fifo_ctrl_rwsthp.sv
// Valid/ready FIFO sequencer driving a two-port RAM with registered address and output stages.
// Optional write-to-output bypass on an empty FIFO is enabled by defining NV_FIFO_CTRL_BYPASS_EN.
module nv_fifo_ctrl_rwsthp #(
  parameter int DEPTH = 19,
  parameter int WIDTH = 4,
  parameter int AW    = 5
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rstn,
  nv_fifo_ctrl_rwsthp_if.slave  io,
  output logic [AW-1:0]         ram_wa,
  output logic                  ram_we,
  output logic [WIDTH-1:0]      ram_di,
  output logic [AW-1:0]         ram_ra,
  output logic                  ram_re,
  output logic                  ram_ore,
  output logic                  ram_byp_sel,
  output logic [WIDTH-1:0]      ram_dbyp,
  input  logic [WIDTH-1:0]      ram_dout,
  output logic [AW:0]           fifo_cnt,
  output logic                  idle
);

  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_V  = (AW + 1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   unread_cnt;
  logic          s1_vld;
  logic          s2_vld;

  logic [AW:0]   slot_cnt;
  logic          wr_acc;
  logic          s1_adv;
  logic          byp;

  // The stage-1 entry keeps its RAM slot reserved until it moves into the output register.
  assign slot_cnt = unread_cnt + {{AW{1'b0}}, s1_vld};
  assign fifo_cnt = slot_cnt + {{AW{1'b0}}, s2_vld};
  assign idle     = (fifo_cnt == '0) & ~s1_vld & ~s2_vld;

  assign io.wr_prdy = (slot_cnt < DEPTH_V);
  assign wr_acc     = io.wr_pvld & io.wr_prdy;

`ifdef NV_FIFO_CTRL_BYPASS_EN
  assign byp = wr_acc & (unread_cnt == '0) & ~s1_vld & (~s2_vld | io.rd_prdy);
`else
  assign byp = 1'b0;
`endif

  assign ram_we      = wr_acc & ~byp;
  assign ram_wa      = wr_ptr;
  assign ram_di      = io.wr_pd;
  assign ram_dbyp    = io.wr_pd;
  assign ram_byp_sel = byp;

  // Read issue only looks at registered occupancy, so a slot is never read in its write cycle.
  assign s1_adv  = s1_vld & (~s2_vld | io.rd_prdy);
  assign ram_re  = (unread_cnt != '0) & (~s1_vld | s1_adv);
  assign ram_ra  = rd_ptr;
  assign ram_ore = s1_adv | byp;

  assign io.rd_pvld = s2_vld;
  assign io.rd_pd   = ram_dout;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      unread_cnt <= '0;
      s1_vld     <= 1'b0;
      s2_vld     <= 1'b0;
    end else begin
      if (ram_we) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (ram_re) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      unread_cnt <= unread_cnt + {{AW{1'b0}}, ram_we} - {{AW{1'b0}}, ram_re};
      s1_vld     <= ram_re | (s1_vld & ~s1_adv);
      s2_vld     <= ram_ore | (s2_vld & ~io.rd_prdy);
    end
  end

endmodule

// File: tb/tb_nv_fifo_ctrl_rwsthp.sv
// Self-checking bench for nv_fifo_ctrl_rwsthp: behavioural RAM plus a transaction-level
// queue model predicting occupancy, ready/valid timing and the returned data order.
module tb_nv_fifo_ctrl_rwsthp;

  localparam int DEPTH = 19;
  localparam int WIDTH = 4;
  localparam int AW    = 5;
`ifdef NV_FIFO_CTRL_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 3;
`endif

  logic             clk;
  logic             rst_n;
  logic [AW-1:0]    ram_wa;
  logic             ram_we;
  logic [WIDTH-1:0] ram_di;
  logic [AW-1:0]    ram_ra;
  logic             ram_re;
  logic             ram_ore;
  logic             ram_byp_sel;
  logic [WIDTH-1:0] ram_dbyp;
  logic [WIDTH-1:0] ram_dout;
  logic [AW:0]      fifo_cnt;
  logic             idle;

  nv_fifo_ctrl_rwsthp_if #(.WIDTH(WIDTH)) bus ();

  nv_fifo_ctrl_rwsthp #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rst_n),
    .io              (bus.slave),
    .ram_wa          (ram_wa),
    .ram_we          (ram_we),
    .ram_di          (ram_di),
    .ram_ra          (ram_ra),
    .ram_re          (ram_re),
    .ram_ore         (ram_ore),
    .ram_byp_sel     (ram_byp_sel),
    .ram_dbyp        (ram_dbyp),
    .ram_dout        (ram_dout),
    .fifo_cnt        (fifo_cnt),
    .idle            (idle)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural two-port RAM: registered read address, registered output with bypass mux
  logic [WIDTH-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0]    ra_q;
  logic [WIDTH-1:0] dout_q;
  always @(posedge clk) begin
    if (ram_we)  mem[ram_wa] <= ram_di;
    if (ram_re)  ra_q <= ram_ra;
    if (ram_ore) dout_q <= ram_byp_sel ? ram_dbyp : mem[ra_q];
  end
  assign ram_dout = dout_q;

  // scoreboard / reference model
  logic [WIDTH-1:0] exp_q[$];
  int               rdy_q[$];
  int               cyc;
  int               wa_m;
  int               ra_m;
  bit               last_push;
  int               n_compared;
  int               n_mismatched;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    rdy_q.delete();
    wa_m = 0;
    ra_m = 0;
  endtask

  // One clock cycle: inputs are already driven; check at the falling edge, update the model.
  task automatic step();
    int   cnt;
    logic exp_vld;
    logic exp_rdy;
    bit   pop;
    bit   byp_m;
    @(negedge clk);
    cnt     = exp_q.size();
    exp_vld = (cnt != 0) && (rdy_q[0] <= cyc);
    exp_rdy = ((cnt - int'(exp_vld)) < DEPTH);
    check_eq("rd_pvld", bus.rd_pvld, exp_vld);
    check_eq("fifo_cnt", fifo_cnt, cnt);
    check_eq("idle", idle, cnt == 0);
    check_eq("wr_prdy", bus.wr_prdy, exp_rdy);
    if (exp_vld) check_eq("rd_pd", bus.rd_pd, exp_q[0]);
    pop       = exp_vld && bus.rd_prdy;
    last_push = bus.wr_pvld && exp_rdy;
    if (pop) begin
      void'(exp_q.pop_front());
      void'(rdy_q.pop_front());
    end
    byp_m = 1'b0;
`ifdef NV_FIFO_CTRL_BYPASS_EN
    byp_m = last_push && (exp_q.size() == 0);
`endif
    check_eq("ram_byp_sel", ram_byp_sel, byp_m);
    check_eq("ram_we", ram_we, last_push && !byp_m);
    if (last_push && !byp_m) begin
      check_eq("ram_wa", ram_wa, wa_m);
      wa_m = (wa_m + 1) % DEPTH;
    end
    if (ram_re) begin
      check_eq("ram_ra", ram_ra, ra_m);
      ra_m = (ra_m + 1) % DEPTH;
    end
    if (last_push) begin
      exp_q.push_back(bus.wr_pd);
      rdy_q.push_back(cyc + (byp_m ? 1 : 3));
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // driver tasks
  task automatic drive_idle();
    bus.wr_pvld = 1'b0;
    bus.wr_pd   = '0;
    bus.rd_prdy = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_rd_pvld"}, bus.rd_pvld, 1'b0);
    check_eq({tag, "_fifo_cnt"}, fifo_cnt, 0);
    check_eq({tag, "_idle"}, idle, 1'b1);
    check_eq({tag, "_wr_prdy"}, bus.wr_prdy, 1'b1);
    check_eq({tag, "_ram_ctl"}, {ram_we, ram_re, ram_ore, ram_byp_sel}, 4'b0000);
  endtask

  task automatic drain();
    int n;
    bus.wr_pvld = 1'b0;
    bus.rd_prdy = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) check_eq("drain_timeout", fifo_cnt, 0);
    bus.rd_prdy = 1'b0;
  endtask

  initial begin
    int lat;
    int k;
    int n;
    logic [WIDTH-1:0] pat;
    n_compared   = 0;
    n_mismatched = 0;
    cyc          = 0;
    model_clear();
    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // T2: single write into an empty FIFO
    bus.rd_prdy = 1'b1;
    bus.wr_pvld = 1'b1;
    bus.wr_pd   = 4'hA;
    step();
    bus.wr_pvld = 1'b0;
    lat = 1;
    while (!bus.rd_pvld && lat < 8) begin
      step();
      lat++;
    end
    check_eq("t2_latency", lat, LAT);
    check_eq("t2_data", bus.rd_pd, 4'hA);
    drain();

    // T3 / T5: fill with the consumer stalled, then exercise the full boundary
    bus.rd_prdy = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      pat         = WIDTH'(i);
      bus.wr_pvld = 1'b1;
      bus.wr_pd   = pat;
      step();
    end
    check_eq("t3_full_cnt", fifo_cnt, DEPTH + 1);
    check_eq("t3_full_prdy", bus.wr_prdy, 1'b0);
    bus.rd_prdy = 1'b1;
    bus.wr_pd   = 4'h7;
    step();
    bus.rd_prdy = 1'b0;
    check_eq("t5_prdy_after_pop", bus.wr_prdy, 1'b1);
    check_eq("t5_cnt_after_pop", fifo_cnt, DEPTH);
    step();
    check_eq("t5_cnt_refill", fifo_cnt, DEPTH + 1);
    check_eq("t5_prdy_refill", bus.wr_prdy, 1'b0);
    drain();

    // T4: streaming past the pointer wrap
    bus.rd_prdy = 1'b1;
    k = 0;
    n = 0;
    while (k < 50 && n < 500) begin
      bus.wr_pvld = 1'b1;
      bus.wr_pd   = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      step();
      if (last_push) k++;
      n++;
    end
    check_eq("t4_accepted", k, 50);
    drain();

    // T6: random payloads under random backpressure
    k = 0;
    n = 0;
    while (k < 1000 && n < 20000) begin
      bus.wr_pvld = ($urandom_range(0, 3) != 0);
      bus.wr_pd   = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      bus.rd_prdy = ($urandom_range(0, 1) == 1);
      step();
      if (last_push) k++;
      n++;
    end
    check_eq("t6_accepted", k, 1000);
    drain();

    // T1: reset in the middle of traffic
    for (int i = 0; i < 12; i++) begin
      bus.wr_pvld = 1'b1;
      bus.wr_pd   = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      bus.rd_prdy = ($urandom_range(0, 1) == 1);
      step();
    end
    drive_idle();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("midreset");
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.rd_prdy = 1'b1;
    bus.wr_pvld = 1'b1;
    bus.wr_pd   = 4'h5;
    step();
    bus.wr_pvld = 1'b0;
    lat = 1;
    while (!bus.rd_pvld && lat < 8) begin
      step();
      lat++;
    end
    check_eq("t1_latency", lat, LAT);
    check_eq("t1_first_data", bus.rd_pd, 4'h5);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
